// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder cell stepped LSB-first over WIDTH cycles.
// Optional SERIAL_ADD_OVF_EN adds o_ovf, the two's-complement overflow of the last result.

module full_adder (
    input  logic i_switch_a,
    input  logic i_switch_b,
    input  logic i_cin,
    output logic o_cout,
    output logic o_sum
);
    assign o_sum  = i_switch_a ^ i_switch_b ^ i_cin;
    assign o_cout = (i_switch_a & i_switch_b) | (i_cin & (i_switch_a ^ i_switch_b));
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             o_ovf
`endif
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             carry_q;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] s_next;

    full_adder u_fa (
        .i_switch_a (a_sr[0]),
        .i_switch_b (b_sr[0]),
        .i_cin      (carry_q),
        .o_cout     (fa_cout),
        .o_sum      (fa_sum)
    );

    // Sum bits enter at the MSB and drift down, so after WIDTH steps bit 0 is the LSB.
    assign s_next = {fa_sum, s_sr[WIDTH-1:1]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
            s_sr    <= '0;
            carry_q <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_sum   <= '0;
            o_cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            o_ovf   <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        a_sr    <= i_a;
                        b_sr    <= i_b;
                        carry_q <= i_cin;
                        s_sr    <= '0;
                        cnt     <= '0;
                        o_busy  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    s_sr    <= s_next;
                    carry_q <= fa_cout;
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    cnt     <= cnt + CW'(1);
                    // Last bit: publish result; carry_q here is the carry into the MSB.
                    if (cnt == CW'(WIDTH - 1)) begin
                        o_sum  <= s_next;
                        o_cout <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                        o_ovf  <= carry_q ^ fa_cout;
`endif
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: vector table, scoreboard, and timing corner cases.

module tb_serial_add_ctrl;
    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .i_cin   (cin),
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
        .o_cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .o_ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(1), 32'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("cout", 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // Pulse start for one edge, then measure busy length and done position relative to the accept edge.
    task automatic run_op(input vec_t v, input string tag);
        int busy_cnt;
        int done_at;
        exp_t e;
        e.sum  = v.sum;
        e.cout = v.cout;
        e.ovf  = v.ovf;
        @(posedge clk); #1;
        a = v.a; b = v.b; cin = v.cin; start = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
        busy_cnt = 0;
        done_at  = -1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_at = j;
                break;
            end
        end
        check({tag, "_done_at"}, 32'(done_at), 32'(WIDTH));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
    endtask

    vec_t vecs[7];

    initial begin
        int   ndone;
        int   viol;
        time  t[3];
        bit   dropped;

        vecs[0] = '{a: 8'h05, b: 8'h03, cin: 1'b0, sum: 8'h08, cout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h7F, b: 8'h00, cin: 1'b1, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1, ovf: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
        vecs[5] = '{a: 8'hAA, b: 8'h55, cin: 1'b0, sum: 8'hFF, cout: 1'b0, ovf: 1'b0};
        vecs[6] = '{a: 8'h12, b: 8'h34, cin: 1'b0, sum: 8'h46, cout: 1'b0, ovf: 1'b0};

        // Reset held with start asserted: nothing may launch.
        rst = 1'b1; start = 1'b1; a = 8'h55; b = 8'h22; cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_sum", 32'(sum), 32'(0));
        check("rst_cout", 32'(cout), 32'(0));
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", 32'(ovf), 32'(0));
`endif

        for (int i = 0; i < 6; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // Start while busy must be ignored.
        begin
            exp_t e;
            e = '{sum: 8'h30, cout: 1'b0, ovf: 1'b0};
            @(posedge clk); #1;
            a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
            sb.push_back(e);
            @(posedge clk); #1;           // edge k accepted
            start = 1'b0;
            @(posedge clk); @(posedge clk); #1;
            a = 8'hAA; start = 1'b1;      // sampled at edge k+3
            @(posedge clk); #1;
            start = 1'b0;
            ndone = 0;
            for (int j = 0; j < 20; j++) begin
                @(negedge clk);
                if (done) ndone++;
            end
            check("busy_start_dones", 32'(ndone), 32'(1));
        end

        // Back-to-back: start held high for three results.
        begin
            exp_t e;
            e = '{sum: 8'h02, cout: 1'b0, ovf: 1'b0};
            repeat (3) sb.push_back(e);
            ndone = 0; viol = 0; dropped = 1'b0;
            @(posedge clk); #1;
            a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
            @(posedge clk);
            for (int j = 0; j < 40; j++) begin
                @(negedge clk);
                if (done) begin
                    t[ndone] = $time;
                    ndone++;
                end
                if (busy == done) viol++;
                if (ndone == 3) break;
                if (ndone == 2 && !dropped) begin
                    @(posedge clk); #1;
                    start = 1'b0;
                    dropped = 1'b1;
                end
            end
            check("b2b_dones", 32'(ndone), 32'(3));
            check("b2b_gap1", 32'(t[1] - t[0]), 32'(90));
            check("b2b_gap2", 32'(t[2] - t[1]), 32'(90));
            check("b2b_busy_pattern", 32'(viol), 32'(0));
        end

        // Reset mid-operation aborts silently and clears the result.
        @(posedge clk); #1;
        a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;               // edge k
        start = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;                       // sampled at edge k+4
        @(posedge clk); #1;
        rst = 1'b0;
        ndone = 0; viol = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (done) ndone++;
            if (busy) viol++;
        end
        check("abort_dones", 32'(ndone), 32'(0));
        check("abort_busy", 32'(viol), 32'(0));
        check("abort_sum", 32'(sum), 32'(0));
        check("abort_cout", 32'(cout), 32'(0));

        run_op(vecs[6], "post_abort");

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller.
- Sequences one instance of the team's one-bit full_adder cell (ports i_switch_a, i_switch_b, i_cin, o_cout, o_sum) over WIDTH clock cycles, LSB first.
- Produces a WIDTH-bit sum and carry-out with a start/done handshake.
- Trades latency for area on the MAX 10 board designs. Sits between switch/host operand registers and the display/result logic.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- i_clk  input  1  system clock; all state changes on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  request a new addition; sampled only in IDLE.
- i_a  input  WIDTH  operand A; captured when start is accepted.
- i_b  input  WIDTH  operand B; captured when start is accepted.
- i_cin  input  1  carry-in; captured when start is accepted.
- o_busy  output  1  high while an addition is in progress (RUN).
- o_done  output  1  one-cycle pulse: result registers just updated.
- o_sum  output  WIDTH  result of the last completed addition; held until the next completion.
- o_cout  output  1  carry-out of the last completed addition; held.

Behaviour:
- Clock i_clk, single domain. Reset i_rst is synchronous and active-high.
- Reset (any state): state=IDLE, counter=0, shift registers=0, carry register=0. o_busy=0, o_done=0, o_sum=0, o_cout=0.
- States: IDLE, RUN. Encoding is free.
- IDLE:
  - o_busy=0.
  - If i_start=1 at edge k: load a_sr<=i_a, b_sr<=i_b, carry_q<=i_cin, s_sr<=0, cnt<=0, state<=RUN.
  - Otherwise hold.
- RUN:
  - o_busy=1.
  - Full-adder inputs: a_sr[0], b_sr[0], carry_q.
  - Each edge: s_sr<={fa_sum, s_sr[WIDTH-1:1]}; carry_q<=fa_cout; a_sr and b_sr shift right by one (zero fill); cnt<=cnt+1.
  - When cnt==WIDTH-1 at an edge:
    - o_sum<={fa_sum, s_sr[WIDTH-1:1]}
    - o_cout<=fa_cout
    - o_done<=1
    - state<=IDLE
- Latency: start accepted at edge k. o_busy=1 for cycles after edges k..k+WIDTH-1. o_done=1 for exactly the cycle after edge k+WIDTH.
- o_done is deasserted on every other edge. It is never high for two consecutive cycles except on back-to-back completions, which cannot occur because WIDTH>=2.
- i_start while in RUN is ignored: no queuing, and operands are not re-captured.
- i_start during the o_done cycle (state already IDLE) is accepted. Back-to-back throughput is one result per WIDTH+1 cycles.
- Operand inputs may change freely after the accept edge.
- Arithmetic is unsigned modulo 2^WIDTH. o_cout is bit WIDTH of i_a+i_b+i_cin.
- Counter width: clog2(WIDTH). No wrap occurs beyond WIDTH-1 because the state leaves RUN at that count.
- Reset mid-RUN: the operation is aborted, o_done is not pulsed, and o_sum/o_cout are cleared to 0.
- Reset has priority over i_start in the same cycle.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Adds output port o_ovf, 1 bit: two's-complement overflow of the last completed addition.
  - o_ovf<=carry_q XOR fa_cout at the final RUN edge (carry into MSB XOR carry out of MSB).
  - o_ovf updates with o_sum, holds until the next completion, and resets to 0.
- Undefined: port o_ovf and its register are absent. All other behaviour is identical.

Test Plan:
- Reset: hold i_rst=1 for 2 edges with i_start=1 → o_busy=0, o_done=0, o_sum=8'h00, o_cout=0; no op starts.
- Basic: WIDTH=8, i_a=8'h05, i_b=8'h03, i_cin=0, i_start pulse at edge k → o_busy=1 for 8 cycles; o_done=1 only after edge k+8; o_sum=8'h08, o_cout=0.
- Carry/overflow:
  - i_a=8'hFF, i_b=8'h01, i_cin=0 → o_sum=8'h00, o_cout=1, o_ovf=0.
  - i_a=8'h7F, i_b=8'h00, i_cin=1 → o_sum=8'h80, o_cout=0, o_ovf=1 (OVF build).
- Start while busy: start i_a=8'h10, i_b=8'h20; at edge k+3 assert i_start with i_a=8'hAA → single o_done at k+8, o_sum=8'h30.
- Back-to-back: i_start held high continuously with i_a=8'h01, i_b=8'h01 → o_done pulses every 9 cycles, o_sum=8'h02 each time, o_busy low only in o_done cycles.
- Reset mid-op: start 8'hF0+8'h0F, i_rst=1 at edge k+4 → o_busy=0 and o_done never pulses; o_sum=8'h00. A subsequent start with 8'h12+8'h34 yields o_sum=8'h46.
